// File: rtl/cfg_frame_encoder_if.sv
// Producer/UART-side bus of the config frame encoder.
// master: the clock module and UART transmitter; slave: the encoder.
interface cfg_frame_encoder_if;
   logic       valid;
   logic [3:0] address;
   logic [3:0] data;
   logic       ack;
   logic       tx_busy;
   logic       send;
   logic [8:0] frame_to_transmit;
   logic       fault;
   logic [2:0] pending;

   modport master (
      output valid, address, data, tx_busy,
      input  ack, send, frame_to_transmit, fault, pending
   );

   modport slave (
      input  valid, address, data, tx_busy,
      output ack, send, frame_to_transmit, fault, pending
   );
endinterface

// File: rtl/cfg_frame_encoder.sv
// Buffers address/data readback words in a small FIFO and sends each one to
// the UART as a 9-bit odd-parity frame, retrying unstarted sends and flagging
// stalls and dropped frames with a sticky fault.
module cfg_frame_encoder #(
   parameter int unsigned FifoDepth    = 4,
   parameter int unsigned StartTimeout = 64,
   parameter int unsigned MaxRetry     = 3,
   parameter int unsigned StallTimeout = 255
) (
   input logic                clk_i,
   input logic                rst_ni,
   cfg_frame_encoder_if.slave bus
);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned TmrW = $clog2(StartTimeout + 1);
   localparam int unsigned RtyW = $clog2(MaxRetry + 1);
   localparam int unsigned StlW = $clog2(StallTimeout + 1);

   typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitStart, StWaitDone} state_e;

   logic [7:0]      mem_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic [StlW-1:0] stall_q, stall_d;
   logic [TmrW-1:0] timer_q;
   logic [RtyW-1:0] retry_q;
   logic [8:0]      frame_q;
   logic            ack_q, send_q, fault_q;
   state_e          state_q;

   logic       full, push, pop, stall_hit, timer_done, drop;
   logic [7:0] head;

   assign full       = (count_q == CntW'(FifoDepth));
   assign push       = bus.valid && !full && !ack_q;
   assign pop        = (state_q == StLoad);
   assign head       = mem_q[rd_ptr_q];
   assign timer_done = (timer_q == TmrW'(StartTimeout - 1));
   assign drop       = (state_q == StWaitStart) && !bus.tx_busy && timer_done &&
                       (retry_q == RtyW'(MaxRetry));

   // Next occupancy and stall count
   always_comb begin
      count_d   = count_q;
      stall_d   = stall_q;
      stall_hit = 1'b0;
      if (push && !pop) count_d = count_q + CntW'(1);
      else if (!push && pop) count_d = count_q - CntW'(1);
      if (!bus.valid || push) begin
         stall_d = '0;
      end else if (full && !ack_q && stall_q != StlW'(StallTimeout)) begin
         stall_d   = stall_q + StlW'(1);
         stall_hit = (stall_d == StlW'(StallTimeout));
      end
   end

   // Word storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {bus.address, bus.data};
   end

   // FIFO pointers, occupancy, accept pulse, stall counter and sticky fault
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= '0;
         ack_q    <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         ack_q   <= push;
         count_q <= count_d;
         stall_q <= stall_d;
         fault_q <= fault_q | stall_hit | drop;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   // Transmit sequencer with registered send/frame outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         frame_q <= '0;
         send_q  <= 1'b0;
         timer_q <= '0;
         retry_q <= '0;
      end else begin
         unique case (state_q)
            // Skip the ack cycle so a fresh word always spends one cycle in IDLE
            StIdle: begin
               if (count_q != '0 && !bus.tx_busy && !ack_q) state_q <= StLoad;
            end
            StLoad: begin
               frame_q <= {~^head, head};
               send_q  <= 1'b1;
               state_q <= StSend;
            end
            StSend: begin
               send_q  <= 1'b0;
               timer_q <= '0;
               state_q <= StWaitStart;
            end
            StWaitStart: begin
               if (bus.tx_busy) begin
                  retry_q <= '0;
                  state_q <= StWaitDone;
               end else if (timer_done) begin
                  if (retry_q < RtyW'(MaxRetry)) begin
                     retry_q <= retry_q + RtyW'(1);
                     send_q  <= 1'b1;
                     state_q <= StSend;
                  end else begin
                     retry_q <= '0;
                     state_q <= StIdle;
                  end
               end else begin
                  timer_q <= timer_q + TmrW'(1);
               end
            end
            StWaitDone: begin
               if (!bus.tx_busy) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ack               = ack_q;
   assign bus.send              = send_q;
   assign bus.frame_to_transmit = frame_q;
   assign bus.fault             = fault_q;
   assign bus.pending           = 3'(count_q);
endmodule
